// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency word memory behind valid/ready request and
//               response channels, with misaligned/out-of-range error responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
        if (DEPTH_WORDS < 2 || DEPTH_WORDS > 4096 ||
            (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH_WORDS must be a power of two in 2..4096");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, busy_q, valid_q, err_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          w_accept;
    logic          w_access;
    logic          w_we;
    logic [31:0]   w_addr, w_wdata;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign w_accept = (state_q == S_IDLE) && ready_q && req_valid;

    // With LATENCY=1 the access happens on the accepting edge, so it must use
    // the live request rather than the latched copy.
    assign w_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign w_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign w_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_idx   = w_addr[AW+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cnt_d = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d  = S_RESP;
                        w_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d  = S_RESP;
                    w_access = 1'b1;
                end
            end
            S_RESP: begin
                if (valid_q && resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            ready_q <= (state_d == S_IDLE);
            if (w_accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                busy_q  <= 1'b1;
            end
            if (w_access) begin
                valid_q <= 1'b1;
                err_q   <= w_err;
                rdata_q <= (w_err || w_we) ? 32'd0 : mem_q[w_idx];
            end else if (state_q == S_RESP && resp_ready) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
                busy_q  <= 1'b0;
            end
        end
    end

    // Storage survives reset; a reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (!reset && w_access && w_we && !w_err) begin
            mem_q[w_idx] <= w_wdata;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for dmem_responder at LATENCY 2, 4 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rv        [3];
    logic        rr        [3];
    logic        rq_ready  [3];
    logic        rsp_valid [3];
    logic        rsp_err   [3];
    logic        bsy       [3];
    logic [31:0] rsp_rdata [3];

    int passed;
    int total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rq_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsp_valid[0]), .resp_ready(rr[0]), .resp_rdata(rsp_rdata[0]),
        .resp_err(rsp_err[0]), .busy(bsy[0]));

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rq_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsp_valid[1]), .resp_ready(rr[1]), .resp_rdata(rsp_rdata[1]),
        .resp_err(rsp_err[1]), .busy(bsy[1]));

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(rq_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsp_valid[2]), .resp_ready(rr[2]), .resp_rdata(rsp_rdata[2]),
        .resp_err(rsp_err[2]), .busy(bsy[2]));

    // Issue one request to DUT d and collect its response with resp_ready held high.
    // lat counts cycles from the accepting cycle to the first resp_valid cycle.
    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output logic rdy_after);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata;
        rr[d] = 1'b1; rv[d] = 1'b1;
        n = 0;
        while (!rq_ready[d] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (!rq_ready[d]) $display("FAIL accept_timeout dut=%0d req_ready=%b required 1", d, rq_ready[d]);
        else passed++;
        @(posedge clk); #1;
        rv[d] = 1'b0;
        rdy_after = rq_ready[d];
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (!rsp_valid[d]) $display("FAIL resp_timeout dut=%0d resp_valid=%b required 1", d, rsp_valid[d]);
        else passed++;
        rdata = rsp_rdata[d];
        err = rsp_err[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({rq_ready[d], rsp_valid[d], rsp_err[d], bsy[d], rsp_rdata[d]} !== 36'd0)
                $display("FAIL reset_outputs dut=%0d got ready=%b valid=%b err=%b busy=%b rdata=%h required all 0",
                         d, rq_ready[d], rsp_valid[d], rsp_err[d], bsy[d], rsp_rdata[d]);
            else passed++;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rq_ready[d] !== 1'b1) $display("FAIL ready_after_reset dut=%0d got %b required 1", d, rq_ready[d]);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat; logic ra;
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, ra);
        total++;
        if (ra !== 1'b0) $display("FAIL wr_ready_after_accept got %b required 0", ra); else passed++;
        total++;
        if (lat != 2) $display("FAIL wr_latency got %0d required 2", lat); else passed++;
        total++;
        if ({er, rd} !== 33'd0) $display("FAIL wr_resp got err=%b rdata=%h required err=0 rdata=0", er, rd); else passed++;
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, ra);
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0)
            $display("FAIL rd_after_wr got err=%b rdata=%h required err=0 rdata=deadbeef", er, rd);
        else passed++;
        total++;
        if (lat != 2) $display("FAIL rd_latency got %0d required 2", lat); else passed++;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat; logic ra;
        access(0, 1'b1, 32'h13, 32'h1234, rd, er, lat, ra);
        total++;
        if (er !== 1'b1 || rd !== 32'd0)
            $display("FAIL misaligned_wr got err=%b rdata=%h required err=1 rdata=0", er, rd);
        else passed++;
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, ra);
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0)
            $display("FAIL misaligned_untouched got err=%b rdata=%h required err=0 rdata=deadbeef", er, rd);
        else passed++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat; logic ra;
        access(0, 1'b0, 32'h100, 32'h0, rd, er, lat, ra);
        total++;
        if (er !== 1'b1 || rd !== 32'd0)
            $display("FAIL oor_read got err=%b rdata=%h required err=1 rdata=0", er, rd);
        else passed++;
        // 0x100 aliases word 0 in the low index bits, so an errant write would show there.
        access(0, 1'b1, 32'h0, 32'h11111111, rd, er, lat, ra);
        access(0, 1'b1, 32'h100, 32'h22222222, rd, er, lat, ra);
        total++;
        if (er !== 1'b1) $display("FAIL oor_write_err got %b required 1", er); else passed++;
        access(0, 1'b0, 32'h0, 32'h0, rd, er, lat, ra);
        total++;
        if (rd !== 32'h11111111 || er !== 1'b0)
            $display("FAIL oor_untouched got err=%b rdata=%h required err=0 rdata=11111111", er, rd);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        rr[0] = 1'b0; rv[0] = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF || rq_ready[0] !== 1'b0)
                $display("FAIL bp_hold cycle=%0d got valid=%b rdata=%h ready=%b required valid=1 rdata=deadbeef ready=0",
                         i, rsp_valid[0], rsp_rdata[0], rq_ready[0]);
            else passed++;
            @(posedge clk); #1;
        end
        rr[0] = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rsp_valid[0] !== 1'b0 || rq_ready[0] !== 1'b1 || bsy[0] !== 1'b0 || rsp_rdata[0] !== 32'd0)
            $display("FAIL bp_release got valid=%b ready=%b busy=%b rdata=%h required valid=0 ready=1 busy=0 rdata=0",
                     rsp_valid[0], rq_ready[0], bsy[0], rsp_rdata[0]);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic er; int lat; logic ra;
        access(1, 1'b1, 32'h20, 32'h0, rd, er, lat, ra);
        total++;
        if (lat != 4) $display("FAIL l4_latency got %0d required 4", lat); else passed++;
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        rr[1] = 1'b1; rv[1] = 1'b1;
        @(posedge clk); #1;
        rv[1] = 1'b0;
        total++;
        if (bsy[1] !== 1'b1) $display("FAIL mid_busy got %b required 1", bsy[1]); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rq_ready[1], rsp_valid[1], rsp_err[1], bsy[1], rsp_rdata[1]} !== 36'd0)
            $display("FAIL mid_reset_outputs got ready=%b valid=%b err=%b busy=%b rdata=%h required all 0",
                     rq_ready[1], rsp_valid[1], rsp_err[1], bsy[1], rsp_rdata[1]);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        access(1, 1'b0, 32'h20, 32'h0, rd, er, lat, ra);
        total++;
        if (rd !== 32'd0 || er !== 1'b0)
            $display("FAIL mid_reset_no_write got err=%b rdata=%h required err=0 rdata=0", er, rd);
        else passed++;
    endtask

    task automatic test_latency1_sweep();
        logic [31:0] rd; logic er; int lat; logic ra;
        for (int i = 0; i < 16; i++) begin
            access(2, 1'b1, 32'(4 * i), 32'h1000 + 32'(i), rd, er, lat, ra);
            total++;
            if (lat != 1 || er !== 1'b0)
                $display("FAIL l1_write idx=%0d got lat=%0d err=%b required lat=1 err=0", i, lat, er);
            else passed++;
        end
        for (int i = 0; i < 16; i++) begin
            access(2, 1'b0, 32'(4 * i), 32'h0, rd, er, lat, ra);
            total++;
            if (lat != 1 || er !== 1'b0 || rd !== 32'h1000 + 32'(i))
                $display("FAIL l1_read idx=%0d got lat=%0d err=%b rdata=%h required lat=1 err=0 rdata=%h",
                         i, lat, er, rd, 32'h1000 + 32'(i));
            else passed++;
        end
    endtask

    initial begin
        passed = 0; total = 0;
        reset = 1'b1;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int d = 0; d < 3; d++) begin
            rv[d] = 1'b0; rr[d] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_op();
        test_latency1_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data port. Serves one word read or write at a time over a valid/ready request channel and a valid/ready response channel.
- Access latency is a fixed, configurable number of cycles, which lets the CPU side be exercised against a non-ideal memory.
- Word-addressed storage; flags misaligned and out-of-range accesses with an error response instead of touching storage.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in storage (power of two, 2..4096)
LATENCY, 2, cycles from request acceptance to resp_valid (1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  read data (0 for writes and errors)
resp_err  output  1  access was misaligned or out of range
busy  output  1  a request is accepted and not yet retired

Behaviour:
- Reset values: req_ready=0 during reset, 1 on the first cycle after reset deasserts. resp_valid=0, resp_rdata=0, resp_err=0, busy=0, FSM=IDLE, latency counter=0.
- Storage contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch we/addr/wdata, load counter with LATENCY-1, set busy=1, and go to WAIT.
  - If LATENCY=1, go directly to RESP.
- WAIT:
  - req_ready=0. Counter decrements each cycle.
  - When counter=0 on a clock edge, go to RESP and perform the access on that edge.
- Access rules:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - err = (addr[1:0]!=0) or (addr[31:2] >= DEPTH_WORDS).
  - err=1: no storage write; resp_rdata=0; resp_err=1.
  - Write with no error: storage[index] <= wdata on the RESP-entry edge; resp_rdata=0.
  - Read with no error: resp_rdata = storage[index] as sampled on the RESP-entry edge.
- Total latency: resp_valid first rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - On resp_valid & resp_ready: clear resp_valid, resp_err and resp_rdata, set busy=0, go to IDLE.
  - req_ready is 0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake.
- Requester rule: req_valid may drop without acceptance (no stickiness is required of the requester). Request inputs are don't-care outside IDLE.
- Back-to-back accesses: write followed by read to the same address returns the new data, since the write commits before the read is even accepted.
- Reset mid-operation:
  - In WAIT: abort; no storage write occurs.
  - In RESP: the write has already committed; the response is discarded.
- One outstanding transaction maximum; no reordering.
- Counter width is 4 bits. LATENCY outside 1..15 is a configuration error, checked by an elaboration-time guard.

Test Plan:
- Reset, LATENCY=2: write addr 0x10 data 0xDEADBEEF, resp_ready=1. Expect req_ready=0 after acceptance, resp_valid exactly 2 cycles later with err=0, rdata=0. Then read 0x10: rdata=0xDEADBEEF, err=0.
- Misaligned write to 0x13 with data 0x1234, then read 0x10. Expect the write response err=1, then the read returns 0xDEADBEEF unchanged.
- Read of address 0x100 with DEPTH_WORDS=64: resp_err=1, resp_rdata=0, storage untouched.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid. Expect resp_valid and rdata stable throughout and req_ready=0. The handshake on cycle 6 returns to IDLE, with req_ready=1 on the next cycle.
- Reset mid-operation: accept a write to 0x20 of 0xCAFEF00D with LATENCY=4, assert reset 1 cycle later. Expect all outputs at reset values, and a subsequent read of 0x20 returns its prior value (0 after a preload of 0).
- LATENCY=1 sweep of 16 write/read pairs to addresses 0x00..0x3C with data 0x1000+i. Expect each read to match, and each response to arrive 1 cycle after acceptance.
